// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the CRC accelerator register map.
package axi_lite_pkg;
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam logic [7:0] CRC_INITIAL = 8'h00;
    localparam logic [7:0] CRC_DATA    = 8'h04;
    localparam logic [7:0] CRC_RESULT  = 8'h08;
endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus between one initiator and one register slave.
interface axi_lite_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid, awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid, wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid, bready;
    logic [1:0]                bresp;
    logic                      arvalid, arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid, rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one cmd in, one AXI transaction, one rsp out.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ERRCNT_W   = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic [ERRCNT_W-1:0]   err_count,
    axi_lite_master_if.master     m
);
    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    resp_t                 resp_q, resp_d;
    logic [ERRCNT_W-1:0]   err_q, err_d;
    logic                  cap;
    resp_t                 cap_resp;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        err_d       = err_q;
        cap         = 1'b0;
        cap_resp    = RESP_OKAY;
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    write_d     = cmd_write;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave only when both are done
                if (awvalid_q && m.awready) awvalid_d = 1'b0;
                if (wvalid_q && m.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m.bvalid) begin
                    cap      = 1'b1;
                    cap_resp = m.bresp;
                    resp_d   = m.bresp;
                    rdata_d  = '0;
                    state_d  = RESP;
                end
            end
            RD_ADDR: begin
                if (m.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m.rvalid) begin
                    cap      = 1'b1;
                    cap_resp = m.rresp;
                    resp_d   = m.rresp;
                    rdata_d  = m.rdata;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cap && cap_resp != RESP_OKAY && err_q != '1)
            err_d = err_q + ERRCNT_W'(1);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_write = write_q;
    assign err_count = err_q;

    // address and data stay on the bus until the response is consumed
    assign m.awvalid = awvalid_q;
    assign m.awaddr  = addr_q;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = '1;
    assign m.bready  = (state_q == WR_RESP);
    assign m.arvalid = arvalid_q;
    assign m.araddr  = addr_q;
    assign m.rready  = (state_q == RD_DATA);
endmodule
